// File: rtl/main_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_ctrl_if
// Brief    : Cache-to-main-memory request/response bundle.
// Revision : 1.0
// ============================================================================
interface main_mem_ctrl_if;
    logic        cache_op;
    logic        cache_valid;
    logic [31:0] mem_addr;
    logic [31:0] cache_write_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        mem_err;

    modport master (
        output cache_op, cache_valid, mem_addr, cache_write_data,
        input  mem_ready, mem_data, mem_err
    );

    modport slave (
        input  cache_op, cache_valid, mem_addr, cache_write_data,
        output mem_ready, mem_data, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_ctrl
// Brief    : Word-addressed main memory behind the cache; one outstanding
//            request, fixed latency (MEM_RANDOM_LAT_EN adds 0..3 LFSR cycles).
// Revision : 1.0
// ============================================================================
module main_mem_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          RD_LAT     = 3,
    parameter int          WR_LAT     = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    main_mem_ctrl_if.slave bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_RECOV = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_lat;
    logic                  r_op;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic                  r_mem_ready;
    logic [31:0]           r_mem_data;
    logic                  r_mem_err;
    logic                  w_addr_err;
    logic [31:0]           r_mem [c_DEPTH];

    assign w_addr_err = (bus.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0;

`ifdef MEM_RANDOM_LAT_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lat     = (bus.cache_op ? 8'(RD_LAT) : 8'(WR_LAT)) + {6'd0, r_lfsr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == S_IDLE && bus.cache_valid) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^bus.mem_addr[1:0];
`else
    assign w_lat = bus.cache_op ? 8'(RD_LAT) : 8'(WR_LAT);

    logic w_unused_ok;
    assign w_unused_ok = ^{bus.mem_addr[1:0], LFSR_SEED};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // RESP is the cycle that produces the response; mem_ready is visible during RECOV.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.cache_valid) w_next = (w_lat == 8'd1) ? S_RESP : S_BUSY;
            S_BUSY:  if (r_cnt <= 8'd1) w_next = S_RESP;
            S_RESP:  w_next = S_RECOV;
            S_RECOV: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_op        <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 32'd0;
            r_mem_ready <= 1'b0;
            r_mem_data  <= 32'd0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cache_valid) begin
                        r_op    <= bus.cache_op;
                        r_idx   <= bus.mem_addr[ADDR_WIDTH+1:2];
                        r_wdata <= bus.cache_write_data;
                        r_err   <= w_addr_err;
                        r_cnt   <= w_lat - 8'd1;
                    end
                end
                S_BUSY: r_cnt <= r_cnt - 8'd1;
                S_RESP: begin
                    r_mem_ready <= 1'b1;
                    r_mem_err   <= r_err;
                    if (r_op) r_mem_data <= r_mem[r_idx];
                end
                S_RECOV: begin
                    r_mem_ready <= 1'b0;
                    r_mem_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Array is never reset; an asynchronous reset forces IDLE, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP && !r_op) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_data  = r_mem_data;
    assign bus.mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_ctrl
// Brief    : Scoreboard bench for main_mem_ctrl: directed scenarios followed
//            by random traffic against an array/queue reference model.
// Revision : 1.0
// ============================================================================
module tb_main_mem_ctrl;

    localparam int          c_RD_LAT = 3;
    localparam int          c_WR_LAT = 2;
    localparam int          c_AW     = 10;
    localparam logic [15:0] c_SEED   = 16'hACE1;

    typedef struct {
        int          acc;
        int          lat;
        bit          is_rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    bit   [31:0] ref_mem [1024];
    logic [31:0] last_rd;
    logic [15:0] m_lfsr;

    main_mem_ctrl_if bus ();

    main_mem_ctrl #(
        .ADDR_WIDTH (c_AW),
        .RD_LAT     (c_RD_LAT),
        .WR_LAT     (c_WR_LAT),
        .LFSR_SEED  (c_SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Issue one request from a point just after a rising edge; returns one
    // cycle after mem_ready so the next request lands on the earliest accept edge.
    task automatic do_req(input logic op, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   idx;
        int   n;
        idx     = int'(addr[11:2]);
        e.acc   = cyc + 1;
        e.is_rd = op;
        e.err   = (addr[31:12] != 20'd0);
        e.lat   = op ? c_RD_LAT : c_WR_LAT;
`ifdef MEM_RANDOM_LAT_EN
        e.lat  += int'(m_lfsr) % 4;
        m_lfsr  = lfsr_step(m_lfsr);
`endif
        if (op) last_rd = ref_mem[idx];
        else    ref_mem[idx] = wd;
        e.data = last_rd;
        sb.push_back(e);

        bus.cache_op         = op;
        bus.mem_addr         = addr;
        bus.cache_write_data = wd;
        bus.cache_valid      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.mem_ready !== 1'b1 && n < 30);
        if (bus.mem_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got no mem_ready expected one within 30 cycles (addr 0x%08h)", addr);
            sb.delete();
        end
        if (!hold) bus.cache_valid = 1'b0;
        @(posedge clk); #1;
        bus.cache_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst !== 1'b1 && bus.mem_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got mem_ready=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("mem_data", bus.mem_data, e.data);
                    check("mem_err", {31'd0, bus.mem_err}, {31'd0, e.err});
`ifdef MEM_RANDOM_LAT_EN
                    if (e.is_rd)
                        check("rd_lat_range", {31'd0, (cyc - e.acc >= 3 && cyc - e.acc <= 6)}, 32'd1);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected $finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        int          idx;
        bus.cache_op         = 1'b0;
        bus.cache_valid      = 1'b0;
        bus.mem_addr         = 32'd0;
        bus.cache_write_data = 32'd0;
        rst                  = 1'b1;
        m_lfsr               = c_SEED;
        last_rd              = 32'd0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_mem_data", bus.mem_data, 32'd0);
        check("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_mem_ready", {31'd0, bus.mem_ready}, 32'd0);

        do_req(1'b0, 32'h0000_0010, 32'h1111_0000, 1'b0);
        do_req(1'b1, 32'h0000_0010, 32'h0, 1'b0);
        do_req(1'b0, 32'h0001_0010, 32'h1010_1010, 1'b0);
        do_req(1'b1, 32'h0000_0010, 32'h0, 1'b0);
        do_req(1'b1, 32'h0000_0010, 32'h0, 1'b1);
        do_req(1'b1, 32'h0000_0004, 32'h0, 1'b0);

        // Reset while the write to 0x20 is still in flight.
        bus.cache_op         = 1'b0;
        bus.mem_addr         = 32'h0000_0020;
        bus.cache_write_data = 32'hDEAD_BEEF;
        bus.cache_valid      = 1'b1;
        @(posedge clk); #1;
        rst             = 1'b1;
        bus.cache_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_busy_no_ready", {31'd0, bus.mem_ready}, 32'd0);
        end
        rst     = 1'b0;
        m_lfsr  = c_SEED;
        last_rd = 32'd0;
        check("rst_busy_mem_data", bus.mem_data, 32'd0);
        @(posedge clk); #1;
        do_req(1'b1, 32'h0000_0020, 32'h0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_req(1'b1, 32'($urandom_range(0, 63)) << 2, 32'h0, 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15));
            a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1023)) << 12);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
